// File: rtl/fir_out_quantizer.sv
// fir_out_quantizer: rounds, saturates and decimates the 32-bit FIR output
// down to 16 bits, then buffers the kept samples in a small output FIFO.
//
// Ports
//   clk_tb      in   rising-edge clock
//   reset_tb    in   asynchronous active-high reset
//   enable      in   run request; low stops accepting and drains the FIFO
//   in_valid    in   in_data valid this cycle (no backpressure toward the FIR)
//   in_data     in   32-bit signed filtered sample
//   out_ready   in   downstream accepts out_data this cycle
//   out_valid   out  FIFO non-empty, out_data valid
//   out_data    out  16-bit signed quantized sample at the FIFO head
//   fifo_count  out  current FIFO occupancy
//   overflow    out  sticky: a kept sample was dropped because the FIFO was full
//   sat_flag    out  one-cycle pulse: a kept sample was saturated
module fir_out_quantizer #(
    parameter int unsigned SHIFT = 15,
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_tb,
    input  logic                     reset_tb,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [15:0]              out_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     sat_flag
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [32:0] ROUND = 33'(64'd1 << (SHIFT - 1));
    localparam logic signed [32:0] Q_MAX = 33'sd32767;
    localparam logic signed [32:0] Q_MIN = -33'sd32768;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              accept_c;
    logic              cnt_clear_c;
    logic [DW-1:0]     dec_cnt;
    logic              keep_c;

    logic signed [32:0] round_sum_c;
    logic signed [32:0] shifted_c;
    logic [15:0]        quant_c;
    logic               sat_c;

    logic              s1_keep;
    logic [15:0]       s1_data;

    logic [15:0]       mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_next_c;
    logic              pop_c;
    logic              full_c;
    logic              wr_en_c;
    logic [CW-1:0]     count_next_c;
    logic [CW-1:0]     after_pop_c;
    logic [15:0]       head_next_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Quantizer: 33-bit add so the rounding constant can never wrap
    always_comb begin
        round_sum_c = $signed({in_data[31], in_data}) + ROUND;
        shifted_c   = round_sum_c >>> SHIFT;
        quant_c     = shifted_c[15:0];
        sat_c       = 1'b0;
        if (shifted_c > Q_MAX) begin
            quant_c = 16'h7FFF;
            sat_c   = 1'b1;
        end else if (shifted_c < Q_MIN) begin
            quant_c = 16'h8000;
            sat_c   = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; DRAIN waits for both stage 1 and the FIFO to empty
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if ((fifo_count == '0) && !s1_keep) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        accept_c    = 1'b0;
        cnt_clear_c = 1'b0;
        case (state_q)
            ST_IDLE: cnt_clear_c = 1'b1;
            ST_RUN:  accept_c    = in_valid;
            default: ;
        endcase
    end

    assign keep_c = (dec_cnt == '0);

    // Decimation counter; held at zero in IDLE so the first sample is kept
    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            dec_cnt <= '0;
        end else if (cnt_clear_c) begin
            dec_cnt <= '0;
        end else if (accept_c) begin
            dec_cnt <= (dec_cnt == DW'(DECIM - 1)) ? '0 : dec_cnt + DW'(1);
        end
    end

    // Stage 1: registered quantized sample, keep flag and saturation pulse
    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            s1_keep  <= 1'b0;
            s1_data  <= '0;
            sat_flag <= 1'b0;
        end else begin
            s1_keep  <= accept_c & keep_c;
            sat_flag <= accept_c & keep_c & sat_c;
            if (accept_c && keep_c) begin
                s1_data <= quant_c;
            end
        end
    end

    // FIFO control; a pop frees the slot so a push into a full FIFO still lands
    always_comb begin
        pop_c        = out_valid & out_ready;
        full_c       = (fifo_count == CW'(DEPTH));
        wr_en_c      = s1_keep & (~full_c | pop_c);
        count_next_c = fifo_count + CW'(wr_en_c) - CW'(pop_c);
        after_pop_c  = fifo_count - CW'(pop_c);
        rd_next_c    = pop_c ? ptr_inc(rd_ptr) : rd_ptr;
        // Head after the edge: bypass the incoming sample when nothing else remains
        head_next_c  = (after_pop_c == '0) ? s1_data : mem[rd_next_c];
    end

    // FIFO storage
    always_ff @(posedge clk_tb) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= s1_data;
        end
    end

    // FIFO pointers, occupancy and registered head
    always_ff @(posedge clk_tb or posedge reset_tb) begin
        if (reset_tb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr     <= rd_next_c;
            fifo_count <= count_next_c;
            out_valid  <= (count_next_c != '0);
            if (count_next_c != '0) begin
                out_data <= head_next_c;
            end
            if (s1_keep && full_c && !pop_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Bench for fir_out_quantizer: two instances (DECIM=1 and DECIM=4) share
// stimulus and are compared every cycle against a queue-style model, plus
// directed checks of rounding, decimation, backpressure, reset and drain.
module tb_fir_out_quantizer;

    localparam int DEPTH  = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DRAIN = 2;

    logic        clk_tb = 1'b0;
    logic        reset_tb = 1'b1;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        ov1, ovf1, sat1;
    logic [15:0] od1;
    logic [2:0]  cnt1;
    logic        ov4, ovf4, sat4;
    logic [15:0] od4;
    logic [2:0]  cnt4;

    int total = 0;
    int bad = 0;

    // Model state, index 0 = DECIM 1, index 1 = DECIM 4
    int mdec [2] = '{1, 4};
    int mmode[2];
    int mcnt [2];
    int mlen [2];
    int mfifo[2][DEPTH];
    bit ms1k [2];
    int ms1d [2];
    bit movf [2];
    int mout [2];
    bit msat [2];

    always #5 clk_tb = ~clk_tb;

    fir_out_quantizer #(.SHIFT(15), .DECIM(1), .DEPTH(4)) dut1 (
        .clk_tb(clk_tb), .reset_tb(reset_tb), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
        .out_valid(ov1), .out_data(od1), .fifo_count(cnt1),
        .overflow(ovf1), .sat_flag(sat1)
    );

    fir_out_quantizer #(.SHIFT(15), .DECIM(4), .DEPTH(4)) dut4 (
        .clk_tb(clk_tb), .reset_tb(reset_tb), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
        .out_valid(ov4), .out_data(od4), .fifo_count(cnt4),
        .overflow(ovf4), .sat_flag(sat4)
    );

    task automatic check(input string tag, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference quantizer: real-valued rounding then clamp
    function automatic int quant(input logic [31:0] din, output bit sat);
        longint v;
        v = longint'($signed(din));
        v = (v + 64'sd16384) >>> 15;
        sat = 1'b0;
        if (v > 32767) begin v = 32767; sat = 1'b1; end
        if (v < -32768) begin v = -32768; sat = 1'b1; end
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mmode[d] = M_IDLE; mcnt[d] = 0; mlen[d] = 0;
            ms1k[d] = 1'b0; ms1d[d] = 0; movf[d] = 1'b0;
            mout[d] = 0; msat[d] = 1'b0;
        end
    endtask

    task automatic model_edge(input int d);
        int  pre_len;
        bit  pre_s1, pop, acc, keep, sat;
        int  qv;
        pre_len = mlen[d];
        pre_s1  = ms1k[d];
        pop = (pre_len > 0) && out_ready;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mfifo[d][i] = mfifo[d][i + 1];
            mlen[d]--;
        end
        if (pre_s1) begin
            if (pre_len == DEPTH && !pop) movf[d] = 1'b1;
            else begin
                mfifo[d][mlen[d]] = ms1d[d];
                mlen[d]++;
            end
        end
        if (mlen[d] > 0) mout[d] = mfifo[d][0];
        acc  = (mmode[d] == M_RUN) && in_valid;
        keep = acc && (mcnt[d] == 0);
        qv   = quant(in_data, sat);
        ms1k[d] = keep;
        if (keep) ms1d[d] = qv;
        msat[d] = keep && sat;
        if (mmode[d] == M_IDLE) mcnt[d] = 0;
        else if (acc) mcnt[d] = (mcnt[d] + 1) % mdec[d];
        case (mmode[d])
            M_IDLE:  if (enable) mmode[d] = M_RUN;
            M_RUN:   if (!enable) mmode[d] = M_DRAIN;
            default: begin
                if (enable) mmode[d] = M_RUN;
                else if (pre_len == 0 && !pre_s1) mmode[d] = M_IDLE;
            end
        endcase
    endtask

    task automatic check_dut(input int d, input logic v, input logic [15:0] data,
                             input logic [2:0] cnt, input logic ovf, input logic sf);
        check($sformatf("dut%0d out_valid", d), longint'(v), longint'(mlen[d] > 0));
        check($sformatf("dut%0d out_data", d), longint'($signed(data)), longint'(mout[d]));
        check($sformatf("dut%0d fifo_count", d), longint'(cnt), longint'(mlen[d]));
        check($sformatf("dut%0d overflow", d), longint'(ovf), longint'(movf[d]));
        check($sformatf("dut%0d sat_flag", d), longint'(sf), longint'(msat[d]));
    endtask

    // One clock: drive at negedge, advance model at posedge, check at next negedge
    task automatic cycle(input bit en, input bit iv, input logic [31:0] din, input bit rdy);
        enable = en; in_valid = iv; in_data = din; out_ready = rdy;
        @(posedge clk_tb);
        if (!reset_tb) begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge clk_tb);
        check_dut(0, ov1, od1, cnt1, ovf1, sat1);
        check_dut(1, ov4, od4, cnt4, ovf4, sat4);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ov1"}, longint'(ov1), 0);   check({tag, " od1"}, longint'(od1), 0);
        check({tag, " cnt1"}, longint'(cnt1), 0); check({tag, " ovf1"}, longint'(ovf1), 0);
        check({tag, " sat1"}, longint'(sat1), 0); check({tag, " ov4"}, longint'(ov4), 0);
        check({tag, " od4"}, longint'(od4), 0);   check({tag, " cnt4"}, longint'(cnt4), 0);
        check({tag, " ovf4"}, longint'(ovf4), 0); check({tag, " sat4"}, longint'(sat4), 0);
    endtask

    // Asynchronous reset, outputs checked before any clock edge
    task automatic do_reset();
        reset_tb = 1'b1;
        #1;
        model_reset();
        check_zero("async reset");
        @(negedge clk_tb);
        reset_tb = 1'b0;
    endtask

    task automatic send_round(input logic [31:0] din, input int exp, input bit exp_sat);
        cycle(1, 1, din, 1);
        check("round sat_flag", longint'(sat1), longint'(exp_sat));
        cycle(1, 0, 0, 1);
        check("round out_valid", longint'(ov1), 1);
        check("round out_data", longint'($signed(od1)), longint'(exp));
        cycle(1, 0, 0, 1);
    endtask

    initial begin
        int got[8];
        int ngot;
        logic [31:0] r;

        model_reset();
        repeat (2) @(negedge clk_tb);
        check_zero("reset state");
        reset_tb = 1'b0;

        // Rounding and saturation on the DECIM=1 instance
        cycle(1, 0, 0, 1);
        send_round(32'h0000_4000, 1, 0);
        send_round(32'h0000_3FFF, 0, 0);
        send_round(32'hFFFF_C000, 0, 0);
        send_round(32'h3FFF_8000, 32767, 0);
        send_round(32'h4000_0000, 32767, 1);
        send_round(32'h8000_0000, -32768, 1);

        // Decimation: return to IDLE so the DECIM=4 counter restarts
        repeat (6) cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 1);
        ngot = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k <= 8) cycle(1, 1, 32'(k) << 15, 1);
            else cycle(1, 0, 0, 1);
            if (k == 2) begin
                check("decim latency valid", longint'(ov4), 1);
                check("decim latency data", longint'($signed(od4)), 1);
            end
            if (ov4 && ngot < 8) begin
                got[ngot] = int'($signed(od4));
                ngot++;
            end
        end
        check("decim count", ngot, 2);
        check("decim first", got[0], 1);
        check("decim second", got[1], 5);

        // Backpressure with overflow
        for (int k = 1; k <= 5; k++) cycle(1, 1, 32'(k) << 15, 0);
        cycle(1, 0, 0, 0);
        check("bp fifo_count", longint'(cnt1), 4);
        check("bp overflow", longint'(ovf1), 1);
        for (int i = 1; i <= 4; i++) begin
            check("bp order", longint'($signed(od1)), i);
            cycle(1, 0, 0, 1);
        end
        check("bp empty", longint'(ov1), 0);

        // Reset mid-stream with three entries buffered
        for (int k = 0; k < 3; k++) cycle(1, 1, 32'(20 + k) << 15, 0);
        cycle(1, 0, 0, 0);
        check("pre-reset count", longint'(cnt1), 3);
        do_reset();
        repeat (4) cycle(1, 0, 0, 1);
        check("post-reset silent", longint'(ov1), 0);

        // Full FIFO with push and pop on the same edge
        for (int k = 5; k <= 9; k++) cycle(1, 1, 32'(k) << 15, 0);
        check("full count", longint'(cnt1), 4);
        cycle(1, 0, 0, 1);
        check("pushpop count", longint'(cnt1), 4);
        check("pushpop overflow", longint'(ovf1), 0);
        check("pushpop head", longint'($signed(od1)), 6);
        for (int v = 7; v <= 9; v++) begin
            cycle(1, 0, 0, 1);
            check("pushpop order", longint'($signed(od1)), v);
        end
        cycle(1, 0, 0, 1);
        check("pushpop empty", longint'(ov1), 0);

        // Drain: enable dropped with three entries buffered
        for (int k = 0; k < 3; k++) cycle(1, 1, 32'(11 + k) << 15, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("drain count", longint'(cnt1), 3);
        for (int v = 11; v <= 13; v++) begin
            check("drain order", longint'($signed(od1)), v);
            cycle(0, 1, 32'h0010_0000, 1);
        end
        repeat (3) cycle(0, 1, 32'h0010_0000, 1);
        check("drain ignores input", longint'(cnt1), 0);
        check("drain ignores valid", longint'(ov1), 0);
        cycle(1, 0, 0, 1);
        cycle(1, 1, 32'(77) << 15, 1);
        cycle(1, 1, 32'(78) << 15, 1);
        check("reenable keep valid", longint'(ov4), 1);
        check("reenable keep data", longint'($signed(od4)), 77);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: r = 32'($urandom);
                1: r = (32'($urandom_range(0, 400)) << 15) + 32'($urandom_range(16380, 16388)) - 32'd6553600;
                2: r = 32'h3FFF_8000 + 32'($urandom_range(0, 65535)) - 32'd32768;
                default: r = 32'($urandom_range(0, 1000)) << 15;
            endcase
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, r,
                  $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
